// File: rtl/imm_extend_if.sv
// Decode-side stream into the immediate generator and its extended-immediate stream out.
// "slave" is the generator's view; "master" is the view of whoever drives it.
interface imm_extend_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_fmt;
    logic             in_sext;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  in_valid, in_instr, in_fmt, in_sext, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport master (
        output in_valid, in_instr, in_fmt, in_sext, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered multi-format immediate generator with a two-entry (OUT + SKID) output stage.
// in_ready is a flop equal to "SKID empty", so out_ready never reaches it combinationally.
module imm_extend_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input logic         clk,
    input logic         rst,
    imm_extend_if.slave bus
);
    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_Z = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        ST_E = 2'd0,
        ST_O = 2'd1,
        ST_F = 2'd2
    } state_e;

    state_e      state;
    entry_t      in_ent;
    entry_t      out_q;
    entry_t      skid_q;
    logic        out_vld_q;
    logic        rdy_q;
    logic        accept;
    logic        drain;
    logic        fill;
    logic [31:0] i;
    logic        unused_opcode;

    assign i             = bus.in_instr;
    assign unused_opcode = ^i[6:0];

    // Every signed format carries its sign in bit 31; Z never sign-extends.
    assign fill = bus.in_sext & i[31];

    always_comb begin
        in_ent     = '0;
        in_ent.tag = bus.in_tag;
        in_ent.imm = {XLEN{fill}};
        case (bus.in_fmt)
            FMT_I: in_ent.imm[11:0] = i[31:20];
            FMT_S: in_ent.imm[11:0] = {i[31:25], i[11:7]};
            FMT_B: in_ent.imm[12:0] = {i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U: in_ent.imm[31:0] = {i[31:12], 12'b0};
            FMT_J: in_ent.imm[20:0] = {i[31], i[19:12], i[20], i[30:21], 1'b0};
            FMT_Z: begin
                in_ent.imm      = '0;
                in_ent.imm[4:0] = i[19:15];
            end
            default: begin
                in_ent.imm = '0;
                in_ent.err = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid & rdy_q;
    assign drain  = out_vld_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_E;
            out_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            case (state)
                ST_E: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        out_q     <= in_ent;
                        out_vld_q <= 1'b1;
                        state     <= ST_O;
                    end
                end
                ST_O: begin
                    if (accept && !drain) begin
                        skid_q <= in_ent;
                        rdy_q  <= 1'b0;
                        state  <= ST_F;
                    end else if (accept) begin
                        // Drain and refill on the same edge: no bubble.
                        out_q <= in_ent;
                    end else if (drain) begin
                        out_vld_q <= 1'b0;
                        state     <= ST_E;
                    end
                end
                ST_F: begin
                    if (drain) begin
                        out_q <= skid_q;
                        rdy_q <= 1'b1;
                        state <= ST_O;
                    end
                end
                default: begin
                    state     <= ST_E;
                    out_vld_q <= 1'b0;
                    rdy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_tag   = out_q.tag;
    assign bus.out_err   = out_q.err;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomized stimulus for imm_extend_pipe with hand-computed expectations
// and a FIFO scoreboard for the streaming run.
module tb_imm_extend_pipe;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    imm_extend_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_extend_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: pull out the raw field and its width, then extend from its MSB.
    function automatic logic [XLEN:0] ref_model(input logic [31:0] w, input logic [2:0] f,
                                                input logic s);
        logic [31:0]     raw;
        int              wd;
        logic [XLEN-1:0] r;
        raw = '0;
        wd  = 0;
        case (f)
            3'd0: begin raw = {20'b0, w[31:20]}; wd = 12; end
            3'd1: begin raw = {20'b0, w[31:25], w[11:7]}; wd = 12; end
            3'd2: begin raw = {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}; wd = 13; end
            3'd3: begin raw = {w[31:12], 12'b0}; wd = 32; end
            3'd4: begin raw = {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}; wd = 21; end
            3'd5: begin raw = {27'b0, w[19:15]}; wd = 5; s = 1'b0; end
            default: return {1'b1, {XLEN{1'b0}}};
        endcase
        r = '0;
        for (int b = 0; b < XLEN; b++)
            r[b] = (b < wd) ? raw[b] : (s & raw[wd-1]);
        return {1'b0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction for exactly one edge, then withdraw it.
    task automatic drive(input logic [31:0] w, input logic [2:0] f, input logic s,
                         input logic [TAG_W-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_fmt   = f;
        bus.in_sext  = s;
        bus.in_tag   = t;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        bus.in_fmt    = 3'd0;
        bus.in_sext   = 1'b1;
        bus.in_tag    = 5'd9;
        bus.out_ready = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++;
        if ({bus.out_imm, bus.out_tag, bus.out_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: imm %h tag %h err %b want all 0", bus.out_imm, bus.out_tag, bus.out_err);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_i_type();
        bus.out_ready = 1'b1;
        drive(32'hFFF00093, 3'd0, 1'b1, 5'd3);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL i_sext_valid: got %b want 1", bus.out_valid); end
        n_cmp++;
        if (bus.out_imm !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL i_sext_imm: got %h want ffffffffffffffff", bus.out_imm); end
        n_cmp++;
        if (bus.out_tag !== 5'd3) begin n_fail++; $display("FAIL i_sext_tag: got %0d want 3", bus.out_tag); end
        drive(32'hFFF00093, 3'd0, 1'b0, 5'd4);
        n_cmp++;
        if (bus.out_imm !== 64'h0000000000000FFF) begin n_fail++; $display("FAIL i_zext_imm: got %h want fff", bus.out_imm); end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL i_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_b_u_s_z();
        bus.out_ready = 1'b1;
        drive(32'hFE000EE3, 3'd2, 1'b1, 5'd5);
        n_cmp++;
        if (bus.out_imm !== 64'hFFFFFFFFFFFFFFFC) begin n_fail++; $display("FAIL b_imm: got %h want fffffffffffffffc", bus.out_imm); end
        drive(32'h800000B7, 3'd3, 1'b1, 5'd6);
        n_cmp++;
        if (bus.out_imm !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL u_sext_imm: got %h want ffffffff80000000", bus.out_imm); end
        drive(32'h800000B7, 3'd3, 1'b0, 5'd6);
        n_cmp++;
        if (bus.out_imm !== 64'h0000000080000000) begin n_fail++; $display("FAIL u_zext_imm: got %h want 80000000", bus.out_imm); end
        // sw x1,-8(x2): S imm = -8
        drive(32'hFE112C23, 3'd1, 1'b1, 5'd8);
        n_cmp++;
        if (bus.out_imm !== 64'hFFFFFFFFFFFFFFF8) begin n_fail++; $display("FAIL s_imm: got %h want fffffffffffffff8", bus.out_imm); end
        // rs1/zimm field = 31, sext ignored for Z
        drive(32'hFFFFFFFF, 3'd5, 1'b1, 5'd10);
        n_cmp++;
        if (bus.out_imm !== 64'h000000000000001F) begin n_fail++; $display("FAIL z_imm: got %h want 1f", bus.out_imm); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 1'b1, 5'd1);
        n_cmp++;
        if (bus.out_tag !== 5'd1 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_first: tag %0d valid %b want 1/1", bus.out_tag, bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_1: got %b want 1", bus.in_ready); end
        drive(32'h00200093, 3'd0, 1'b1, 5'd2);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00300093;
        bus.in_tag   = 5'd3;
        step();
        step();
        n_cmp++;
        if (bus.out_tag !== 5'd1 || bus.out_imm !== 64'd1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: tag %0d imm %h rdy %b want 1/1/0", bus.out_tag, bus.out_imm, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        n_cmp++;
        if (bus.out_tag !== 5'd2 || bus.out_imm !== 64'd2 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second: tag %0d imm %h rdy %b want 2/2/1", bus.out_tag, bus.out_imm, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_tag !== 5'd3 || bus.out_imm !== 64'd3 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_third: tag %0d imm %h valid %b want 3/3/1", bus.out_tag, bus.out_imm, bus.out_valid);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reserved();
        bus.out_ready = 1'b1;
        drive(32'h12345678, 3'd6, 1'b1, 5'd7);
        n_cmp++;
        if (bus.out_err !== 1'b1 || bus.out_imm !== '0 || bus.out_tag !== 5'd7) begin
            n_fail++; $display("FAIL rsv_fmt6: err %b imm %h tag %0d want 1/0/7", bus.out_err, bus.out_imm, bus.out_tag);
        end
        drive(32'hFFF00093, 3'd0, 1'b1, 5'd8);
        n_cmp++;
        if (bus.out_err !== 1'b0 || bus.out_tag !== 5'd8) begin
            n_fail++; $display("FAIL rsv_clear: err %b tag %0d want 0/8", bus.out_err, bus.out_tag);
        end
        drive(32'hFFFFFFFF, 3'd7, 1'b0, 5'd9);
        n_cmp++;
        if (bus.out_err !== 1'b1 || bus.out_imm !== '0) begin
            n_fail++; $display("FAIL rsv_fmt7: err %b imm %h want 1/0", bus.out_err, bus.out_imm);
        end
        step();
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 1'b1, 5'd11);
        drive(32'h00200093, 3'd0, 1'b1, 5'd12);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rf_full: in_ready %b want 0", bus.in_ready); end
        bus.in_valid = 1'b1;
        rst = 1'b1;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || {bus.out_imm, bus.out_tag, bus.out_err} !== '0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rf_cleared: valid %b imm %h tag %0d err %b rdy %b want all 0",
                               bus.out_valid, bus.out_imm, bus.out_tag, bus.out_err, bus.in_ready);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rf_release: rdy %b valid %b want 1/0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        drive(32'hFFDFF0EF, 3'd4, 1'b1, 5'd13);
        n_cmp++;
        if (bus.out_imm !== 64'hFFFFFFFFFFFFFFFC || bus.out_tag !== 5'd13) begin
            n_fail++; $display("FAIL rf_j_imm: imm %h tag %0d want fffffffffffffffc/13", bus.out_imm, bus.out_tag);
        end
        step();
    endtask

    task automatic test_streaming();
        logic [XLEN+TAG_W:0] exp_q[$];
        logic [XLEN+TAG_W:0] e;
        logic [XLEN:0]       m;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bus.in_valid = 1'b0;
        while ((sent < 100 || got < sent) && cyc < 5000) begin
            if (sent < 100 && !(bus.in_valid && !bus.in_ready)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_instr = $urandom;
                bus.in_fmt   = 3'($urandom_range(0, 7));
                bus.in_sext  = 1'($urandom_range(0, 1));
                bus.in_tag   = TAG_W'($urandom);
            end else if (sent >= 100) begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: unexpected tag %0d imm %h", bus.out_tag, bus.out_imm);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_err, bus.out_imm, bus.out_tag} !== e) begin
                        n_fail++; $display("FAIL stream_item%0d: got err %b imm %h tag %0d want err %b imm %h tag %0d",
                                           got, bus.out_err, bus.out_imm, bus.out_tag,
                                           e[XLEN+TAG_W], e[XLEN+TAG_W-1:TAG_W], e[TAG_W-1:0]);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                m = ref_model(bus.in_instr, bus.in_fmt, bus.in_sext);
                exp_q.push_back({m, bus.in_tag});
                sent++;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (got !== 100 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_count: received %0d pending %0d want 100/0 after %0d cycles",
                               got, exp_q.size(), cyc);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_fmt    = '0;
        bus.in_sext   = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_i_type();
        test_b_u_s_z();
        test_backpressure();
        test_reserved();
        test_reset_full();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined immediate generator for the decode stage: takes a raw 32-bit instruction word and a format code, extracts the scattered immediate field, and sign- or zero-extends it to `XLEN` bits. Replaces the single-format, purely combinational 12-bit extender with a multi-format, parametrised, registered unit. It has a valid/ready handshake and a skid buffer, so it can sit between fetch/decode and the register-read stage at full throughput under backpressure.

## Interface
Parameters:
- `XLEN`, 64: output immediate width; legal values 32 or 64.
- `TAG_W`, 5: width of the sideband tag carried alongside each immediate (e.g. destination register or ROB index).

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  unit can accept; registered output.
- `in_instr`  in  32  raw instruction word.
- `in_fmt`  in  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6/7 reserved.
- `in_sext`  in  1  1 = sign-extend the raw field, 0 = zero-extend.
- `in_tag`  in  TAG_W  sideband, passed through unchanged.
- `out_valid`  out  1  output transaction present.
- `out_ready`  in  1  downstream accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_tag`  out  TAG_W  tag of the transaction on `out_imm`.
- `out_err`  out  1  reserved format code was received.

## Operation
- Raw field extraction, with `i` = `in_instr`:
  - I: `i[31:20]` (12 bits).
  - S: `{i[31:25], i[11:7]}` (12 bits).
  - B: `{i[31], i[7], i[30:25], i[11:8], 0}` (13 bits).
  - U: `{i[31:12], 12'b0}` (32 bits).
  - J: `{i[31], i[19:12], i[20], i[30:21], 0}` (21 bits).
  - Z: `i[19:15]` (5 bits).
- Extension:
  - `in_sext`=1 replicates the raw field's MSB up to bit `XLEN-1`. For U with `XLEN`=32 this is a no-op.
  - `in_sext`=0 fills the upper bits with zeros.
  - Z format is always zero-extended regardless of `in_sext`.
- Reserved `in_fmt` (6, 7): `out_imm`=0 and `out_err`=1 for that transaction only. The transaction still flows through the handshake normally.
- Storage is two entries: a main output register (OUT) and a skid register (SKID). Each entry holds imm, tag, err and a valid bit.
- Accept condition: `in_valid && in_ready` at a rising edge while `rst`=0.
- Entry-state transitions (E=empty; O=OUT full, SKID empty; F=both full):
  - E, accept → O.
  - O, accept, OUT not drained (`out_ready`=0) → F; `in_ready` goes 0.
  - O, accept, OUT drained → O, with new data in OUT.
  - O, no accept, drained → E.
  - F, drained → O; SKID moves to OUT and `in_ready` returns to 1.
  - F never accepts, since `in_ready`=0.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.
- `out_imm`, `out_tag` and `out_err` hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - `out_valid`=0, `out_imm`=0, `out_tag`=0, `out_err`=0.
  - Both entries invalid.
  - `in_ready`=1 from the first edge after `rst` deasserts.
  - While `rst`=1, `in_ready`=0 and inputs are ignored.
- Latency: a transaction accepted at edge N is on the outputs with `out_valid`=1 after edge N (one cycle).
- Throughput: one transaction per cycle while `out_ready`=1.
- `in_ready` is a flop output with no combinational path from `out_ready`. It equals "SKID empty".
- Simultaneous accept and drain in state O: OUT is overwritten with the new data in the same edge, with no bubble.
- Reset mid-operation (any state, including F): all entries are cleared at the reset edge. No stale `out_valid` or data appears after reset releases.
- All extraction and extension is combinational ahead of the entry registers. There are no multi-cycle paths.

## Test plan
- I-type `0xFFF00093`, fmt=0, sext=1, `XLEN`=64 → one cycle later `out_imm`=`0xFFFFFFFFFFFFFFFF`. Same word with sext=0 → `0x0000000000000FFF`.
- B-type `0xFE000EE3` (beq offset -4), fmt=2, sext=1 → `out_imm`=`0xFFFFFFFFFFFFFFFC`. U-type `0x800000B7`, fmt=3: sext=1 → `0xFFFFFFFF80000000`, sext=0 → `0x0000000080000000`.
- Backpressure: hold `out_ready`=0 and present tags 1, 2, 3 back-to-back.
  - Tag 1 lands in OUT and tag 2 in SKID; `in_ready`=0 from the cycle after tag 2 is accepted, and tag 3 is held.
  - Raise `out_ready` → tags 1, 2, 3 appear on consecutive cycles, in order, with no duplicates.
- Reserved fmt=6, any instruction, tag 7 → `out_err`=1, `out_imm`=0, `out_tag`=7. The next valid-format transaction → `out_err`=0.
- Reset in state F: assert `rst` for one cycle → `out_valid`=0 and all outputs 0; `in_ready`=1 one cycle after release; a subsequent J-type `0xFFDFF0EF` (jal -4) → `out_imm`=`0xFFFFFFFFFFFFFFFC`.
- Streaming: 100 random transactions with random `in_valid`/`out_ready` → scoreboard matches the reference extraction model, in order, with zero loss.
